// File: rtl/ccr_unit_if.sv
// Handshake bundle for ccr_unit: ALU flags, flag controls and stack controls in; flags, branch decision and stack status out.
// master drives the execute-stage controls, slave is the condition-code register itself.
interface ccr_unit_if;
    logic       zeroFlagIn;
    logic       negativeFlagIn;
    logic       carryFlagIn;
    logic       overFlowFlagIn;
    logic [3:0] flagWriteMask;
    logic       setCarry;
    logic       clrCarry;
    logic       stall;
    logic       intSave;
    logic       rtiRestore;
    logic [2:0] branchType;
    logic [3:0] flagsOut;
    logic       branchTaken;
    logic [2:0] saveCount;
    logic       stackErr;

    modport master (
        output zeroFlagIn, negativeFlagIn, carryFlagIn, overFlowFlagIn,
        output flagWriteMask, setCarry, clrCarry, stall,
        output intSave, rtiRestore, branchType,
        input  flagsOut, branchTaken, saveCount, stackErr
    );

    modport slave (
        input  zeroFlagIn, negativeFlagIn, carryFlagIn, overFlowFlagIn,
        input  flagWriteMask, setCarry, clrCarry, stall,
        input  intSave, rtiRestore, branchType,
        output flagsOut, branchTaken, saveCount, stackErr
    );
endinterface

// File: rtl/ccr_unit.sv
// Condition-code register with interrupt shadow stack and conditional-branch evaluation; FLAG_BYPASS_EN forwards masked ALU flags into branches.
// Latency: flags/stack visible 1 cycle after the inputs; branchTaken is combinational (0 cycles).
// Backpressure: stall=1 freezes every register; no other flow control, one push/pop per cycle.
module ccr_unit #(
    parameter int SAVE_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    ccr_unit_if.slave bus
);
    logic [3:0]                 flagsQ;
    logic [3:0]                 flagsNext;
    logic [3:0]                 aluFlags;
    logic [3:0]                 branchFlags;
    logic [3:0]                 clearMask;
    logic [3:0]                 topEntry;
    logic [SAVE_DEPTH-1:0][3:0] stackQ;
    logic [SAVE_DEPTH-1:0][3:0] stackNext;
    logic [2:0]                 saveCountQ;
    logic [2:0]                 saveCountNext;
    logic                       stackErrQ;
    logic                       stackErrNext;
    logic                       stackEmpty;
    logic                       stackFull;
    logic                       doRestore;
    logic                       taken;

    assign aluFlags = {bus.overFlowFlagIn, bus.carryFlagIn, bus.negativeFlagIn, bus.zeroFlagIn};

`ifdef FLAG_BYPASS_EN
    // Forward this cycle's ALU result for written bits so a branch right behind a compare sees it.
    assign branchFlags = (bus.flagWriteMask & aluFlags) | (~bus.flagWriteMask & flagsQ);
`else
    assign branchFlags = flagsQ;
`endif

    always_comb begin
        taken     = 1'b0;
        clearMask = 4'b0000;
        if (!bus.stall) begin
            case (bus.branchType)
                3'b001: begin
                    taken        = branchFlags[0];
                    clearMask[0] = branchFlags[0];
                end
                3'b010: begin
                    taken        = branchFlags[1];
                    clearMask[1] = branchFlags[1];
                end
                3'b011: begin
                    taken        = branchFlags[2];
                    clearMask[2] = branchFlags[2];
                end
                3'b100:  taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
    end

    assign stackEmpty = (saveCountQ == 3'd0);
    assign stackFull  = (saveCountQ == 3'(SAVE_DEPTH));
    assign doRestore  = bus.rtiRestore && !stackEmpty;

    always_comb begin
        topEntry = 4'b0000;
        for (int i = 0; i < SAVE_DEPTH; i++) begin
            if (i == int'(saveCountQ) - 1) topEntry = stackQ[i];
        end
    end

    // Lowest priority first, so each later assignment overrides the earlier ones.
    always_comb begin
        flagsNext = (flagsQ & ~bus.flagWriteMask) | (aluFlags & bus.flagWriteMask);
        if (bus.clrCarry)      flagsNext[2] = 1'b0;
        else if (bus.setCarry) flagsNext[2] = 1'b1;
        flagsNext = flagsNext & ~clearMask;
        if (doRestore) flagsNext = topEntry;
    end

    always_comb begin
        stackNext     = stackQ;
        saveCountNext = saveCountQ;
        stackErrNext  = stackErrQ;
        if (bus.intSave && doRestore) begin
            for (int i = 0; i < SAVE_DEPTH; i++) begin
                if (i == int'(saveCountQ) - 1) stackNext[i] = flagsQ;
            end
        end else if (bus.intSave) begin
            if (stackFull) begin
                // Overflow keeps the most recent contexts: drop the oldest, shift down, push on top.
                for (int i = 0; i < SAVE_DEPTH - 1; i++) begin
                    stackNext[i] = stackQ[i+1];
                end
                stackNext[SAVE_DEPTH-1] = flagsQ;
                stackErrNext            = 1'b1;
            end else begin
                for (int i = 0; i < SAVE_DEPTH; i++) begin
                    if (i == int'(saveCountQ)) stackNext[i] = flagsQ;
                end
                saveCountNext = saveCountQ + 3'd1;
            end
        end else if (bus.rtiRestore) begin
            if (stackEmpty) stackErrNext  = 1'b1;
            else            saveCountNext = saveCountQ - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            flagsQ     <= 4'b0000;
            stackQ     <= '0;
            saveCountQ <= 3'd0;
            stackErrQ  <= 1'b0;
        end else if (!bus.stall) begin
            flagsQ     <= flagsNext;
            stackQ     <= stackNext;
            saveCountQ <= saveCountNext;
            stackErrQ  <= stackErrNext;
        end
    end

    assign bus.flagsOut    = flagsQ;
    assign bus.branchTaken = taken;
    assign bus.saveCount   = saveCountQ;
    assign bus.stackErr    = stackErrQ;
endmodule
